// File: rtl/part_mux_pkg.sv
// Shared definitions for the part_mux_scan selector: mode encodings and a
// constant-evaluable clog2 used to size the channel counter.
package part_mux_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/part_mux_scan_ctr.sv
// Modulo-NCH channel register: direct load with range check, scan advance
// with wrap pulse. The register never holds a value >= NCH.
module part_mux_scan_ctr #(
  parameter int NCH  = 8,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [SELW-1:0] load_val,
  input  logic            adv,
  output logic [SELW-1:0] chan,
  output logic            wrap,
  output logic            sel_err
);

  localparam logic [SELW:0]   NCH_W = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

  logic in_range;
  logic at_last;

  assign in_range = {1'b0, load_val} < NCH_W;
  assign at_last  = (chan == LAST);

  // Any load request, valid or not, suppresses the scan advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chan    <= '0;
      wrap    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      wrap    <= adv && !load && at_last;
      sel_err <= load && !in_range;
      if (load) begin
        if (in_range) chan <= load_val;
      end else if (adv) begin
        chan <= at_last ? '0 : chan + 1'b1;
      end
    end
  end

endmodule

// File: rtl/part_mux_scan.sv
// N-channel W-bit 1-of-N selector with registered output, 151-style strobe,
// latched channel register, auto-scan sequencer and hold mode.
module part_mux_scan
  import part_mux_pkg::*;
#(
  parameter int NCH  = 8,
  parameter int W    = 1,
  parameter int SELW = clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH*W-1:0]  data_in,
  input  logic [SELW-1:0]   sel,
  input  logic              sel_load,
  input  logic [1:0]        mode,
  input  logic              ce_n,
  input  logic              step,
  output logic [W-1:0]      q,
  output logic [W-1:0]      q_n,
  output logic [SELW-1:0]   q_chan,
  output logic              q_valid,
  output logic [SELW-1:0]   chan,
  output logic              wrap,
  output logic              sel_err
);

  logic [NCH-1:0][W-1:0] din;
  logic [W-1:0]          q_r;
  logic                  hold;
  logic                  scan;
  logic                  sample;
  logic                  adv;

  assign din    = data_in;
  assign hold   = mode[1];  // 10 and reserved 11 both hold
  assign scan   = (mode_e'(mode) == MODE_SCAN);
  assign sample = !hold && !ce_n && (!scan || step);
  assign adv    = scan && step && !ce_n;

  part_mux_scan_ctr #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (sel_load),
    .load_val (sel),
    .adv      (adv),
    .chan     (chan),
    .wrap     (wrap),
    .sel_err  (sel_err)
  );

  // Sample uses chan before the same-edge load/advance takes effect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r     <= '0;
      q_chan  <= '0;
      q_valid <= 1'b0;
    end else if (hold) begin
      q_valid <= 1'b0;
    end else if (ce_n) begin
      q_r     <= '0;
      q_valid <= 1'b0;
    end else if (sample) begin
      q_r     <= din[chan];
      q_chan  <= chan;
      q_valid <= 1'b1;
    end else begin
      q_valid <= 1'b0;
    end
  end

  // q_n comes off the same flops so the complement holds through reset.
  assign q   = q_r;
  assign q_n = ~q_r;

endmodule

// File: tb/tb_part_mux_scan.sv
// Scoreboarded bench for part_mux_scan: an 8-channel and a 5-channel instance,
// directed stimulus pushes expected samples, negedge monitors pop and compare.
module tb_part_mux_scan;
  import part_mux_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic [8*W-1:0] a_data;
  logic [2:0]     a_sel;
  logic           a_sel_load, a_ce_n, a_step;
  logic [1:0]     a_mode;
  logic [W-1:0]   a_q, a_q_n;
  logic [2:0]     a_q_chan, a_chan;
  logic           a_q_valid, a_wrap, a_sel_err;

  logic [5*W-1:0] b_data;
  logic [2:0]     b_sel;
  logic           b_sel_load, b_ce_n, b_step;
  logic [1:0]     b_mode;
  logic [W-1:0]   b_q, b_q_n;
  logic [2:0]     b_q_chan, b_chan;
  logic           b_q_valid, b_wrap, b_sel_err;

  part_mux_scan #(.NCH(8), .W(W)) dut_a (
    .clk(clk), .reset_n(reset_n), .data_in(a_data), .sel(a_sel),
    .sel_load(a_sel_load), .mode(a_mode), .ce_n(a_ce_n), .step(a_step),
    .q(a_q), .q_n(a_q_n), .q_chan(a_q_chan), .q_valid(a_q_valid),
    .chan(a_chan), .wrap(a_wrap), .sel_err(a_sel_err)
  );

  part_mux_scan #(.NCH(5), .W(W)) dut_b (
    .clk(clk), .reset_n(reset_n), .data_in(b_data), .sel(b_sel),
    .sel_load(b_sel_load), .mode(b_mode), .ce_n(b_ce_n), .step(b_step),
    .q(b_q), .q_n(b_q_n), .q_chan(b_q_chan), .q_valid(b_q_valid),
    .chan(b_chan), .wrap(b_wrap), .sel_err(b_sel_err)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [2:0]   ch;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int v, input int c);
    exp_t e;
    e.q  = W'(v);
    e.ch = 3'(c);
    return e;
  endfunction

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (reset_n && a_q_valid === 1'b1) begin
      if (qa.size() == 0) chk("a_spurious_valid", 32'(a_q_valid), 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_q", 32'(a_q), 32'(e.q));
        chk("a_q_n", 32'(a_q_n), 32'(W'(~e.q)));
        chk("a_q_chan", 32'(a_q_chan), 32'(e.ch));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (reset_n && b_q_valid === 1'b1) begin
      if (qb.size() == 0) chk("b_spurious_valid", 32'(b_q_valid), 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_q", 32'(b_q), 32'(e.q));
        chk("b_q_n", 32'(b_q_n), 32'(W'(~e.q)));
        chk("b_q_chan", 32'(b_q_chan), 32'(e.ch));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    a_sel = '0; a_sel_load = 1'b0; a_mode = MODE_DIRECT; a_ce_n = 1'b1; a_step = 1'b0;
    b_sel = '0; b_sel_load = 1'b0; b_mode = MODE_DIRECT; b_ce_n = 1'b1; b_step = 1'b0;
    for (int c = 0; c < 8; c++) a_data[c*W +: W] = W'(c);
    for (int c = 0; c < 5; c++) b_data[c*W +: W] = W'(c + 1);
    #1;
    chk("rst_a_q", 32'(a_q), 32'h0);
    chk("rst_a_q_n", 32'(a_q_n), 32'hF);
    chk("rst_a_chan", 32'(a_chan), 32'h0);
    chk("rst_a_q_chan", 32'(a_q_chan), 32'h0);
    chk("rst_a_pulses", {29'd0, a_q_valid, a_wrap, a_sel_err}, 32'h0);
    chk("rst_b_q_n", 32'(b_q_n), 32'hF);
    tick(); tick();
    reset_n = 1'b1;

    // DIRECT load of channel 5
    a_data[5*W +: W] = 4'h9;
    a_ce_n = 1'b0; a_sel = 3'd5; a_sel_load = 1'b1;
    qa.push_back(mk(0, 0));
    tick();
    chk("direct_chan", 32'(a_chan), 32'd5);
    a_sel_load = 1'b0;
    qa.push_back(mk(9, 5));
    tick();
    chk("direct_valid", 32'(a_q_valid), 32'd1);

    // strobe off in DIRECT on channel 2
    a_data[2*W +: W] = 4'h7;
    a_sel = 3'd2; a_sel_load = 1'b1;
    qa.push_back(mk(9, 5));
    tick();
    a_sel_load = 1'b0; a_ce_n = 1'b1;
    tick();
    chk("strobe_q", 32'(a_q), 32'h0);
    chk("strobe_q_n", 32'(a_q_n), 32'hF);
    chk("strobe_valid", 32'(a_q_valid), 32'd0);
    chk("strobe_q_chan", 32'(a_q_chan), 32'd5);
    chk("strobe_chan", 32'(a_chan), 32'd2);
    a_ce_n = 1'b0;
    qa.push_back(mk(7, 2));
    tick();

    // mid-run async reset with q = A
    a_data[2*W +: W] = 4'hA;
    qa.push_back(mk(10, 2));
    tick();
    @(negedge clk); #1;
    a_ce_n = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("arst_q", 32'(a_q), 32'h0);
    chk("arst_q_n", 32'(a_q_n), 32'hF);
    chk("arst_chan", 32'(a_chan), 32'h0);
    chk("arst_pulses", {29'd0, a_q_valid, a_wrap, a_sel_err}, 32'h0);
    tick();
    reset_n = 1'b1;

    // SCAN sweep with step held for 10 cycles
    for (int c = 0; c < 8; c++) a_data[c*W +: W] = W'(c);
    a_mode = MODE_SCAN; a_ce_n = 1'b0; a_step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      qa.push_back(mk(i % 8, i % 8));
      tick();
      chk("scan_chan", 32'(a_chan), 32'((i + 1) % 8));
      chk("scan_wrap", 32'(a_wrap), 32'(i == 7));
    end
    a_step = 1'b0;
    tick();
    chk("scan_idle_valid", 32'(a_q_valid), 32'd0);
    chk("scan_idle_chan", 32'(a_chan), 32'd2);

    // collision: load wins over step, sample from old channel
    a_sel = 3'd6; a_sel_load = 1'b1;
    tick();
    a_sel = 3'd3; a_step = 1'b1;
    qa.push_back(mk(6, 6));
    tick();
    chk("coll_chan", 32'(a_chan), 32'd3);
    chk("coll_wrap", 32'(a_wrap), 32'd0);

    // step with strobe inactive does not advance
    a_sel_load = 1'b0; a_ce_n = 1'b1;
    tick();
    chk("step_ce_chan", 32'(a_chan), 32'd3);
    chk("step_ce_q", 32'(a_q), 32'h0);

    // HOLD freezes q while data toggles; sel_load still loads
    a_ce_n = 1'b0;
    qa.push_back(mk(3, 3));
    tick();
    a_mode = MODE_HOLD;
    for (int i = 0; i < 3; i++) begin
      a_data = ~a_data;
      tick();
      chk("hold_q", 32'(a_q), 32'h3);
      chk("hold_valid", 32'(a_q_valid), 32'd0);
    end
    chk("hold_chan", 32'(a_chan), 32'd4);
    a_mode = 2'b11; a_ce_n = 1'b1; a_sel = 3'd1; a_sel_load = 1'b1;
    tick();
    chk("rsvd_q", 32'(a_q), 32'h3);
    chk("rsvd_chan", 32'(a_chan), 32'd1);
    a_sel_load = 1'b0;

    // odd NCH instance: load 4, hold, range error, scan wrap
    b_ce_n = 1'b0; b_sel = 3'd4; b_sel_load = 1'b1;
    qb.push_back(mk(1, 0));
    tick();
    b_sel_load = 1'b0;
    qb.push_back(mk(5, 4));
    tick();
    b_mode = MODE_HOLD;
    for (int i = 0; i < 3; i++) begin
      b_data = ~b_data;
      tick();
      chk("b_hold_q", 32'(b_q), 32'h5);
      chk("b_hold_q_chan", 32'(b_q_chan), 32'd4);
    end
    b_sel = 3'd6; b_sel_load = 1'b1;
    tick();
    chk("b_sel_err", 32'(b_sel_err), 32'd1);
    chk("b_err_chan", 32'(b_chan), 32'd4);
    b_sel_load = 1'b0;
    tick();
    chk("b_sel_err_pulse", 32'(b_sel_err), 32'd0);
    for (int c = 0; c < 5; c++) b_data[c*W +: W] = W'(c + 1);
    b_mode = MODE_SCAN; b_step = 1'b1;
    qb.push_back(mk(5, 4));
    tick();
    chk("b_wrap_chan", 32'(b_chan), 32'd0);
    chk("b_wrap", 32'(b_wrap), 32'd1);
    for (int i = 0; i < 5; i++) begin
      qb.push_back(mk(i + 1, i));
      tick();
      chk("b_scan_chan", 32'(b_chan), 32'((i + 1) % 5));
      chk("b_scan_wrap", 32'(b_wrap), 32'(i == 4));
    end

    a_ce_n = 1'b1; b_ce_n = 1'b1; b_step = 1'b0;
    tick(); tick();
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
